// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the
// pipeline (P) and a long-latency unit (L). P normally wins; after a run of
// cycles where L was kept waiting, one FORCE cycle stalls P and lets L write.
// Also keeps a per-register pending-write scoreboard for long-unit results.
module rf_wb_arbiter #(
    parameter int D_WIDTH       = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int MAX_WAIT      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        p_valid,
    input  logic [ADDRESS_WIDTH-1:0]    p_rd,
    input  logic [D_WIDTH-1:0]          p_data,
    input  logic                        l_valid,
    input  logic [ADDRESS_WIDTH-1:0]    l_rd,
    input  logic [D_WIDTH-1:0]          l_data,
    output logic                        l_ready,
    output logic                        stall,
    input  logic                        iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]    iss_rd,
    output logic [2**ADDRESS_WIDTH-1:0] busy,
    output logic                        wr_en,
    output logic [ADDRESS_WIDTH-1:0]    wr_addr,
    output logic [D_WIDTH-1:0]          wr_data
);

    localparam int NREG = 2**ADDRESS_WIDTH;
    localparam int CW   = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] FORCE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CW:0]     wait_inc;
    logic [NREG-1:0] busy_q, busy_d;
    logic            p_ok;
    logic            grant_p;
    logic            grant_l;
    logic            stall_c;

    // A P request to r0 is void: it never competes for the port.
    assign p_ok     = p_valid && (p_rd != '0);
    // One extra bit so MAX_WAIT=1 cannot wrap the compare.
    assign wait_inc = {1'b0, wait_cnt_q} + {{CW{1'b0}}, 1'b1};

    // Grant selection and next-state; all grants are masked while in reset.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        grant_p    = 1'b0;
        grant_l    = 1'b0;
        stall_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (p_ok) begin
                    grant_p = 1'b1;
                    if (l_valid) begin
                        state_d    = WAIT;
                        wait_cnt_d = {{(CW-1){1'b0}}, 1'b1};
                    end
                end else if (l_valid) begin
                    grant_l = 1'b1;
                end
            end
            WAIT: begin
                if (!l_valid) begin
                    grant_p    = p_ok;
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (!p_ok) begin
                    grant_l    = 1'b1;
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else begin
                    grant_p    = 1'b1;
                    wait_cnt_d = wait_inc[CW-1:0];
                    if (wait_inc >= (CW+1)'(MAX_WAIT)) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                stall_c    = 1'b1;
                grant_l    = l_valid;
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
        if (!rst_n) begin
            grant_p = 1'b0;
            grant_l = 1'b0;
            stall_c = 1'b0;
        end
    end

    // Scoreboard update: a new claim overrides a same-cycle clear; r0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (grant_l) begin
            busy_d[l_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State, wait counter and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign l_ready = grant_l;
    assign stall   = stall_c;
    assign busy    = busy_q;
    assign wr_en   = grant_p || (grant_l && (l_rd != '0));
    assign wr_addr = grant_p ? p_rd   : (grant_l ? l_rd   : '0);
    assign wr_data = grant_p ? p_data : (grant_l ? l_data : '0);

endmodule
